// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
   localparam logic [31:0] WORD_MASK          = 32'hFFFF_FFFC;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam int unsigned DEFAULT_IMEM_DEPTH = 128;

   // What the fetch stage does on a given edge, in priority order.
   typedef enum logic [1:0] {
      ACT_RESET    = 2'd0,
      ACT_REDIRECT = 2'd1,
      ACT_STALL    = 2'd2,
      ACT_ADVANCE  = 2'd3
   } fetch_act_e;

endpackage : mips_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, clears to a nop on flush,
// otherwise captures the fetched word (or a bubble if the fetch was bad).
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        hold,
   input  logic        load_valid,
   input  logic [31:0] ir_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] ir_out,
   output logic [31:0] pc4_out,
   output logic        valid_out
);

   logic [31:0] ir_q,  ir_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   // Next IF/ID contents: reset > flush > hold > load.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ir_d    = ir_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (reset || flush) begin
         ir_d    = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (!hold) begin
         ir_d    = load_valid ? ir_in : NOP_INSTR;
         pc4_d   = pc4_in;
         valid_d = load_valid;
      end
   end

   // IF/ID state register.
   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
   end

   assign ir_out    = ir_q;
   assign pc4_out   = pc4_q;
   assign valid_out = valid_q;

endmodule : if_id_reg

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, reads instruction memory, fills IF/ID, and
// tracks fetch errors and the count of delivered instructions.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] ir,
   output logic        memread,
   output logic [31:0] pc,
   output logic [31:0] if_id_ir,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        fetch_err,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic        fetch_err_q, fetch_err_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_plus4;
   logic        in_range;
   fetch_act_e  act;

   // Memory is idle only while reset is held, so ir is never disturbed then.
   assign memread = ~reset;

   // Decode this edge's action and compute next PC, error flag and counter.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      in_range = ({2'b00, pc_q[31:2]} < IMEM_DEPTH);

      if (reset)         act = ACT_RESET;
      else if (redirect) act = ACT_REDIRECT;
      else if (stall)    act = ACT_STALL;
      else               act = ACT_ADVANCE;

      pc_d          = pc_q;
      fetch_err_d   = fetch_err_q;
      fetch_count_d = fetch_count_q;

      unique case (act)
         ACT_RESET: begin
            pc_d          = RESET_PC;
            fetch_err_d   = 1'b0;
            fetch_count_d = '0;
         end
         ACT_REDIRECT: begin
            // Low bits are dropped; a misaligned target is still flagged.
            pc_d = redirect_pc & WORD_MASK;
            if (redirect_pc[1:0] != 2'b00) fetch_err_d = 1'b1;
         end
         ACT_STALL: begin
         end
         ACT_ADVANCE: begin
            pc_d = pc_plus4;
            if (in_range) begin
               if (fetch_count_q != '1) fetch_count_d = fetch_count_q + 32'd1;
            end else begin
               fetch_err_d = 1'b1;
            end
         end
      endcase
   end

   // PC, sticky error and delivered-instruction counter.
   always_ff @(posedge clk) begin
      pc_q          <= pc_d;
      fetch_err_q   <= fetch_err_d;
      fetch_count_q <= fetch_count_d;
   end

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .hold       (stall),
      .load_valid (in_range),
      .ir_in      (ir),
      .pc4_in     (pc_plus4),
      .ir_out     (if_id_ir),
      .pc4_out    (if_id_pc4),
      .valid_out  (if_id_valid)
   );

   assign pc          = pc_q;
   assign fetch_err   = fetch_err_q;
   assign fetch_count = fetch_count_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random stall/redirect/reset
// traffic, every cycle compared against a cycle-level reference model.
module tb_instr_fetch_unit;

   localparam int unsigned DEPTH = 128;

   logic        clk = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] redirect_pc, ir;
   logic        memread;
   logic [31:0] pc, if_id_ir, if_id_pc4, fetch_count;
   logic        if_id_valid, fetch_err;

   logic [31:0] mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [31:0] m_pc, m_ir, m_pc4, m_cnt;
   logic        m_valid, m_err;

   instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ir          (ir),
      .memread     (memread),
      .pc          (pc),
      .if_id_ir    (if_id_ir),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .fetch_err   (fetch_err),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory: combinational read; out-of-range returns garbage.
   always_comb begin
      if (pc[31:9] == 23'd0) ir = mem[pc[8:2]];
      else                   ir = 32'hBAD0_BAD0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model by the rules, compare everything.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      logic [31:0] nxt;
      reset = r; stall = s; redirect = rd; redirect_pc = rpc;
      #1;
      check("memread", {31'd0, memread}, {31'd0, ~r});
      if (r) begin
         m_pc = 0; m_ir = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_cnt = 0;
      end else if (rd) begin
         m_pc = {rpc[31:2], 2'b00};
         m_ir = 0; m_pc4 = 0; m_valid = 0;
         if (rpc[1:0] != 0) m_err = 1;
      end else if (!s) begin
         nxt = m_pc + 4;
         if ((m_pc / 4) < DEPTH) begin
            m_ir = mem[m_pc / 4];
            m_valid = 1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         end else begin
            m_ir = 0; m_valid = 0; m_err = 1;
         end
         m_pc4 = nxt;
         m_pc = nxt;
      end
      @(posedge clk);
      #1;
      check("pc",          pc,          m_pc);
      check("if_id_ir",    if_id_ir,    m_ir);
      check("if_id_pc4",   if_id_pc4,   m_pc4);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("fetch_err",   {31'd0, fetch_err},   {31'd0, m_err});
      check("fetch_count", fetch_count, m_cnt);
   endtask

   task automatic adv();
      step(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] rpc;
      logic        r, s, rd;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0] = 32'h00222820; mem[1] = 32'h20610006;
      mem[2] = 32'h00823022; mem[3] = 32'hAC640004;
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      @(posedge clk); #1;

      // Reset state.
      do_reset();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);

      // Free run of four fetches.
      adv(); check("t1_ir0", if_id_ir, 32'h00222820);
      adv(); check("t1_ir1", if_id_ir, 32'h20610006);
      adv(); check("t1_ir2", if_id_ir, 32'h00823022);
      adv(); check("t1_ir3", if_id_ir, 32'hAC640004);
      check("t1_pc", pc, 32'h10);
      check("t1_cnt", fetch_count, 32'd4);

      // Stall for two clocks after the first fetch.
      do_reset(); adv();
      step(1'b0, 1'b1, 1'b0, 32'h0); check("t2_hold_pc", pc, 32'h4);
      step(1'b0, 1'b1, 1'b0, 32'h0); check("t2_hold_ir", if_id_ir, 32'h00222820);
      check("t2_cnt", fetch_count, 32'd1);
      adv(); check("t2_resume", if_id_ir, 32'h20610006);

      // Redirect at pc=4 to 0xC costs one bubble.
      do_reset(); adv();
      step(1'b0, 1'b0, 1'b1, 32'hC);
      check("t3_pc", pc, 32'hC);
      check("t3_bubble", {31'd0, if_id_valid}, 32'd0);
      adv();
      check("t3_ir", if_id_ir, 32'hAC640004);
      check("t3_pc4", if_id_pc4, 32'h10);

      // Redirect beats stall.
      adv();
      step(1'b0, 1'b1, 1'b1, 32'h0);
      check("t4_pc", pc, 32'h0);
      check("t4_ir", if_id_ir, 32'h0);
      check("t4_err", {31'd0, fetch_err}, 32'd0);

      // Last word in range, then first word out of range.
      step(1'b0, 1'b0, 1'b1, 32'h1FC);
      adv(); check("t5_last_valid", {31'd0, if_id_valid}, 32'd1);
      adv(); check("t5_oor_valid", {31'd0, if_id_valid}, 32'd0);
      check("t5_err", {31'd0, fetch_err}, 32'd1);
      adv(); adv(); check("t5_sticky", {31'd0, fetch_err}, 32'd1);

      // Misaligned redirect, then reset mid-run.
      do_reset();
      step(1'b0, 1'b0, 1'b1, 32'h6);
      check("t6_pc", pc, 32'h4);
      check("t6_err", {31'd0, fetch_err}, 32'd1);
      step(1'b1, 1'b0, 1'b1, 32'h40);
      check("t6_rst_pc", pc, 32'h0);
      check("t6_rst_err", {31'd0, fetch_err}, 32'd0);

      // PC wraps at the top of the address space.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      adv(); check("wrap_pc", pc, 32'h0);
      do_reset();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         rd = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'h1E0 + $urandom_range(0, 63);
         else begin
            rpc = $urandom_range(0, DEPTH - 1) << 2;
            if ($urandom_range(0, 9) == 0) rpc = rpc | $urandom_range(1, 3);
         end
         step(r, s, rd, rpc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_instr_fetch_unit
